// File: rtl/seq_tx_if.sv
// ============================================================================
// Module      : seq_tx_if
// Description : Request and nibble-bus signals of the sync-framed transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_tx_if #(
   parameter int PAYLOAD_LEN = 4
);
   logic                     start_i;
   logic [4*PAYLOAD_LEN-1:0] payload_i;
   logic                     abort_i;
   logic [3:0]               data_o;
   logic                     valid_o;
   logic                     busy_o;
   logic                     done_o;

   modport master (
      output start_i, payload_i, abort_i,
      input  data_o, valid_o, busy_o, done_o
   );

   modport slave (
      input  start_i, payload_i, abort_i,
      output data_o, valid_o, busy_o, done_o
   );
endinterface

`default_nettype wire

// File: rtl/seq_tx.sv
// ============================================================================
// Module      : seq_tx
// Description : Emits a 1-0-2-4 sync pattern followed by PAYLOAD_LEN nibbles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_tx #(
   parameter int         PAYLOAD_LEN = 4,
   parameter logic [3:0] IDLE_NIBBLE = 4'hF
) (
   input  wire logic clk_i,
   input  wire logic rst_n_i,
   seq_tx_if.slave   bus
);

   localparam int c_CNT_W = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
   localparam int c_SLOTS = 2 ** c_CNT_W;
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(PAYLOAD_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SYNC_1  = 3'd1,
      S_SYNC_0  = 3'd2,
      S_SYNC_2  = 3'd3,
      S_SYNC_4  = 3'd4,
      S_PAYLOAD = 3'd5
   } state_t;

   state_t                   r_state;
   logic [4*PAYLOAD_LEN-1:0] r_payload;
   logic [c_CNT_W-1:0]       r_cnt;
   logic [3:0]               r_data;
   logic                     r_valid;
   logic                     r_busy;
   logic                     r_done;

   logic [3:0]         w_nib [c_SLOTS];
   logic [c_CNT_W-1:0] w_nxt_idx;

   // Nibble table padded to a power of two so the counter indexes it directly.
   for (genvar gi = 0; gi < c_SLOTS; gi++) begin : g_nib
      if (gi < PAYLOAD_LEN) begin : g_used
         assign w_nib[gi] = r_payload[4*gi +: 4];
      end else begin : g_pad
         assign w_nib[gi] = IDLE_NIBBLE;
      end
   end

   assign w_nxt_idx = r_cnt + c_CNT_W'(1);

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_state   <= S_IDLE;
         r_payload <= '0;
         r_cnt     <= '0;
         r_data    <= IDLE_NIBBLE;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == S_IDLE) begin
            if (bus.start_i) begin
               r_payload <= bus.payload_i;
               r_state   <= S_SYNC_1;
               r_data    <= 4'h1;
               r_valid   <= 1'b1;
               r_busy    <= 1'b1;
            end else begin
               r_data  <= IDLE_NIBBLE;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
            end
         end else if (bus.abort_i) begin
            r_state <= S_IDLE;
            r_data  <= IDLE_NIBBLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_SYNC_1: begin
                  r_state <= S_SYNC_0;
                  r_data  <= 4'h0;
               end
               S_SYNC_0: begin
                  r_state <= S_SYNC_2;
                  r_data  <= 4'h2;
               end
               S_SYNC_2: begin
                  r_state <= S_SYNC_4;
                  r_data  <= 4'h4;
               end
               S_SYNC_4: begin
                  r_state <= S_PAYLOAD;
                  r_cnt   <= '0;
                  r_data  <= w_nib[0];
               end
               S_PAYLOAD: begin
                  if (r_cnt == c_LAST) begin
                     r_state <= S_IDLE;
                     r_data  <= IDLE_NIBBLE;
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_cnt  <= w_nxt_idx;
                     r_data <= w_nib[w_nxt_idx];
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_data  <= IDLE_NIBBLE;
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.data_o  = r_data;
   assign bus.valid_o = r_valid;
   assign bus.busy_o  = r_busy;
   assign bus.done_o  = r_done;

endmodule

`default_nettype wire
